// File: rtl/tile_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tile_buffer_pkg : bank state encoding and tile-length clamp           |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package tile_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } buf_state_t;

  // Zero or oversized requests fall back to a full-bank tile count.
  function automatic int clamp_len(input int cfg_tiles, input int tile_count);
    if (cfg_tiles == 0 || cfg_tiles > tile_count) return tile_count;
    return cfg_tiles;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tile_buffer_ctrl : per-bank fill/drain FSM, tile indices, len/keep    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tile_buffer_ctrl
  import tile_buffer_pkg::*;
#(
  parameter int TILE_COUNT = 32,
  parameter int TIW        = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_cfg,
  input  logic [TIW:0]   i_cfg_tiles,
  input  logic           i_cfg_keep,
  input  logic           i_wr,
  input  logic           i_rd,
  output logic [TIW-1:0] o_w_idx,
  output logic [TIW-1:0] o_r_idx,
  output logic           o_writable,
  output logic           o_readable,
  output logic           o_wr_last,
  output logic           o_rd_last,
  output logic           o_full_nxt
);

  localparam logic [TIW:0]   c_len_max = (TIW+1)'(TILE_COUNT);
  localparam logic [TIW:0]   c_len_one = (TIW+1)'(1);
  localparam logic [TIW-1:0] c_idx_one = TIW'(1);

  buf_state_t     r_state, w_state_nxt;
  logic [TIW-1:0] r_w_idx, w_w_idx_nxt;
  logic [TIW-1:0] r_r_idx, w_r_idx_nxt;
  logic [TIW:0]   r_len, w_len_nxt;
  logic           r_keep, w_keep_nxt;
  logic           w_wr_last, w_rd_last;

  assign w_wr_last = ({1'b0, r_w_idx} == (r_len - c_len_one));
  assign w_rd_last = ({1'b0, r_r_idx} == (r_len - c_len_one));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_w_idx <= '0;
      r_r_idx <= '0;
      r_len   <= c_len_max;
      r_keep  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_w_idx <= w_w_idx_nxt;
      r_r_idx <= w_r_idx_nxt;
      r_len   <= w_len_nxt;
      r_keep  <= w_keep_nxt;
    end
  end

  // Configuration wins; the top never offers wr and rd to one bank together.
  always_comb begin
    w_state_nxt = r_state;
    w_w_idx_nxt = r_w_idx;
    w_r_idx_nxt = r_r_idx;
    w_len_nxt   = r_len;
    w_keep_nxt  = r_keep;
    if (i_cfg) begin
      w_state_nxt = ST_EMPTY;
      w_w_idx_nxt = '0;
      w_r_idx_nxt = '0;
      w_len_nxt   = (TIW+1)'(clamp_len(int'(i_cfg_tiles), TILE_COUNT));
      w_keep_nxt  = i_cfg_keep;
    end else if (i_wr) begin
      if (w_wr_last) begin
        w_w_idx_nxt = '0;
        w_state_nxt = ST_FULL;
      end else begin
        w_w_idx_nxt = r_w_idx + c_idx_one;
        w_state_nxt = ST_FILLING;
      end
    end else if (i_rd) begin
      if (w_rd_last) begin
        w_r_idx_nxt = '0;
        w_state_nxt = r_keep ? ST_FULL : ST_EMPTY;
      end else begin
        w_r_idx_nxt = r_r_idx + c_idx_one;
        w_state_nxt = ST_DRAINING;
      end
    end
  end

  always_comb begin
    o_writable = (r_state == ST_EMPTY) || (r_state == ST_FILLING);
    o_readable = (r_state == ST_FULL)  || (r_state == ST_DRAINING);
    o_full_nxt = (w_state_nxt == ST_FULL) || (w_state_nxt == ST_DRAINING);
  end

  assign o_w_idx   = r_w_idx;
  assign o_r_idx   = r_r_idx;
  assign o_wr_last = w_wr_last;
  assign o_rd_last = w_rd_last;

endmodule
`default_nettype wire

// File: rtl/tile_buffer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tile_buffer_bank : multi-bank ping-pong tile staging buffer           |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tile_buffer_bank
  import tile_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int TILE_SIZE    = 32,
  parameter int BUFFER_WIDTH = 8192,
  parameter int BUFFER_COUNT = 2,
  localparam int TILE_WIDTH  = DATA_WIDTH * TILE_SIZE,
  localparam int TILE_COUNT  = BUFFER_WIDTH / TILE_WIDTH,
  localparam int TIW         = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1,
  localparam int BW          = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_valid,
  input  logic [BW-1:0]           cfg_buf,
  input  logic [TIW:0]            cfg_tiles,
  input  logic                    cfg_keep,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [BW-1:0]           wr_buf,
  input  logic [TILE_WIDTH-1:0]   wr_data,
  input  logic                    rd_valid_in,
  output logic                    rd_ready,
  input  logic [BW-1:0]           rd_buf,
  output logic [TILE_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [TIW-1:0]          rd_tile_idx,
  output logic                    wr_done,
  output logic                    rd_done,
  output logic [BUFFER_COUNT-1:0] buf_full
);

  logic [BUFFER_COUNT-1:0]          w_cfg_hit, w_wr_sel, w_rd_sel, w_wr_acc, w_rd_acc;
  logic [BUFFER_COUNT-1:0]          w_writable, w_readable, w_wr_last, w_rd_last, w_full_nxt;
  logic [BUFFER_COUNT-1:0][TIW-1:0] w_w_idx, w_r_idx;
  logic [TIW-1:0]                   w_wr_idx, w_rd_idx;

  // Storage has no reset so it maps onto block RAM.
  logic [TILE_WIDTH-1:0] r_mem [BUFFER_COUNT][TILE_COUNT];

  logic [TILE_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid, r_wr_done, r_rd_done;
  logic [TIW-1:0]          r_rd_tile_idx;
  logic [BUFFER_COUNT-1:0] r_buf_full;

  for (genvar b = 0; b < BUFFER_COUNT; b++) begin : g_bank
    assign w_cfg_hit[b] = cfg_valid && (cfg_buf == BW'(b));
    assign w_wr_sel[b]  = (wr_buf == BW'(b)) && w_writable[b] && !w_cfg_hit[b];
    assign w_rd_sel[b]  = (rd_buf == BW'(b)) && w_readable[b] && !w_cfg_hit[b];
    assign w_wr_acc[b]  = wr_valid && w_wr_sel[b];
    assign w_rd_acc[b]  = rd_valid_in && w_rd_sel[b];

    tile_buffer_ctrl #(
      .TILE_COUNT (TILE_COUNT),
      .TIW        (TIW)
    ) u_ctrl (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_cfg       (w_cfg_hit[b]),
      .i_cfg_tiles (cfg_tiles),
      .i_cfg_keep  (cfg_keep),
      .i_wr        (w_wr_acc[b]),
      .i_rd        (w_rd_acc[b]),
      .o_w_idx     (w_w_idx[b]),
      .o_r_idx     (w_r_idx[b]),
      .o_writable  (w_writable[b]),
      .o_readable  (w_readable[b]),
      .o_wr_last   (w_wr_last[b]),
      .o_rd_last   (w_rd_last[b]),
      .o_full_nxt  (w_full_nxt[b])
    );
  end

  assign wr_ready = |w_wr_sel;
  assign rd_ready = |w_rd_sel;

  always_comb begin
    w_wr_idx = '0;
    w_rd_idx = '0;
    for (int b = 0; b < BUFFER_COUNT; b++) begin
      if (w_wr_sel[b]) w_wr_idx = w_w_idx[b];
      if (w_rd_sel[b]) w_rd_idx = w_r_idx[b];
    end
  end

  always_ff @(posedge clk) begin
    if (|w_wr_acc) r_mem[wr_buf][w_wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_tile_idx <= '0;
      r_wr_done     <= 1'b0;
      r_rd_done     <= 1'b0;
      r_buf_full    <= '0;
    end else begin
      r_rd_valid <= |w_rd_acc;
      r_wr_done  <= |(w_wr_acc & w_wr_last);
      r_rd_done  <= |(w_rd_acc & w_rd_last);
      r_buf_full <= w_full_nxt;
      if (|w_rd_acc) begin
        r_rd_data     <= r_mem[rd_buf][w_rd_idx];
        r_rd_tile_idx <= w_rd_idx;
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rd_tile_idx = r_rd_tile_idx;
  assign wr_done     = r_wr_done;
  assign rd_done     = r_rd_done;
  assign buf_full    = r_buf_full;

endmodule
`default_nettype wire
